// File: rtl/dsc_mul_sequencer.sv
// Sequencer for a deterministic-stochastic serial multiplier: clock-division streams, AND, and a ones count.
// Optional DSC_EARLY_TERM_EN: stop once the B stream is exhausted, and skip RUN entirely for a zero operand.
module dsc_mul_sequencer #(
   parameter int DATA_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     a_in,
   input  logic [DATA_WIDTH-1:0]     b_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*DATA_WIDTH-1:0]   product,
   output logic [2*DATA_WIDTH:0]     cycles,
   output logic                      busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [DATA_WIDTH-1:0]   CTR_MAX = '1;
   localparam logic [DATA_WIDTH-1:0]   CTR_ONE = 1;
   localparam logic [2*DATA_WIDTH:0]   CYC_ONE = 1;

   state_t                    state;
   logic [DATA_WIDTH-1:0]     a_reg;
   logic [DATA_WIDTH-1:0]     b_reg;
   logic [DATA_WIDTH-1:0]     ctr_a;
   logic [DATA_WIDTH-1:0]     ctr_b;
   logic [2*DATA_WIDTH-1:0]   acc;
   logic [2*DATA_WIDTH:0]     cyc_cnt;

   logic                      sa;
   logic                      sb;
   logic                      a_wrap;
   logic                      last_cycle;
   logic                      skip;
   logic [2*DATA_WIDTH-1:0]   acc_next;
   logic [2*DATA_WIDTH:0]     cyc_next;

   always_comb begin
      sa       = (ctr_a < a_reg);
      sb       = (ctr_b < b_reg);
      a_wrap   = (ctr_a == CTR_MAX);
      acc_next = acc + {{(2*DATA_WIDTH-1){1'b0}}, (sa & sb)};
      cyc_next = cyc_cnt + CYC_ONE;
`ifdef DSC_EARLY_TERM_EN
      // Once ctr_b reaches b the B stream is all zeros, so nothing more can be counted.
      last_cycle = a_wrap && (ctr_b == (b_reg - CTR_ONE));
      skip       = (a_in == '0) || (b_in == '0);
`else
      last_cycle = a_wrap && (ctr_b == CTR_MAX);
      skip       = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         ctr_a   <= '0;
         ctr_b   <= '0;
         acc     <= '0;
         cyc_cnt <= '0;
         product <= '0;
         cycles  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg   <= a_in;
                  b_reg   <= b_in;
                  ctr_a   <= '0;
                  ctr_b   <= '0;
                  acc     <= '0;
                  cyc_cnt <= '0;
                  if (skip) begin
                     state   <= DONE;
                     product <= '0;
                     cycles  <= '0;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               acc     <= acc_next;
               cyc_cnt <= cyc_next;
               ctr_a   <= ctr_a + CTR_ONE;
               if (a_wrap) begin
                  ctr_b <= ctr_b + CTR_ONE;
               end
               // The terminal cycle's own bit pair is folded into the published result.
               if (last_cycle) begin
                  state   <= DONE;
                  product <= acc_next;
                  cycles  <= cyc_next;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE) && rst;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dsc_mul_sequencer.sv
// Directed and random bench for dsc_mul_sequencer: a W=4 instance for directed scenarios, a W=3 instance for the sweep.
module tb_dsc_mul_sequencer;

`ifdef DSC_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   int         tests = 0;
   int         fails = 0;

   logic       in_valid4 = 1'b0;
   logic       in_ready4;
   logic [3:0] a4 = '0;
   logic [3:0] b4 = '0;
   logic       out_valid4;
   logic       out_ready4 = 1'b0;
   logic [7:0] product4;
   logic [8:0] cycles4;
   logic       busy4;

   logic       in_valid3 = 1'b0;
   logic       in_ready3;
   logic [2:0] a3 = '0;
   logic [2:0] b3 = '0;
   logic       out_valid3;
   logic       out_ready3 = 1'b0;
   logic [5:0] product3;
   logic [6:0] cycles3;
   logic       busy3;

   always #5 clk = ~clk;

   dsc_mul_sequencer #(.DATA_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .a_in(a4), .b_in(b4), .out_valid(out_valid4), .out_ready(out_ready4),
      .product(product4), .cycles(cycles4), .busy(busy4)
   );

   dsc_mul_sequencer #(.DATA_WIDTH(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
      .a_in(a3), .b_in(b3), .out_valid(out_valid3), .out_ready(out_ready3),
      .product(product3), .cycles(cycles3), .busy(busy3)
   );

   function automatic int exp_cyc4(input int a, input int b);
      if (EARLY) return ((a == 0) || (b == 0)) ? 0 : b * 16;
      return 256;
   endfunction

   function automatic int exp_cyc3(input int a, input int b);
      if (EARLY) return ((a == 0) || (b == 0)) ? 0 : b * 8;
      return 64;
   endfunction

   task automatic start4(input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      a4 = a;
      b4 = b;
      in_valid4 = 1'b1;
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
   endtask

   // Counts edges from the accept edge (which counts as 1) until out_valid is seen.
   task automatic wait_valid4(output int lat, output bit saw_ready);
      lat = 1;
      saw_ready = 1'b0;
      while (!out_valid4 && lat < 600) begin
         if (in_ready4) saw_ready = 1'b1;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic finish4;
      @(negedge clk);
      out_ready4 = 1'b1;
      @(posedge clk);
      #1;
      out_ready4 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (in_ready4 !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready got %0b want 0", in_ready4); end
      tests++;
      if (out_valid4 !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid4); end
      tests++;
      if (product4 !== 8'd0) begin fails++; $display("[TB] FAIL reset_product got %0d want 0", product4); end
      tests++;
      if (cycles4 !== 9'd0) begin fails++; $display("[TB] FAIL reset_cycles got %0d want 0", cycles4); end
      tests++;
      if (busy4 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %0b want 0", busy4); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (in_ready4 !== 1'b1) begin fails++; $display("[TB] FAIL idle_in_ready got %0b want 1", in_ready4); end
   endtask

   task automatic test_basic;
      int lat;
      bit saw;
      start4(4'd5, 4'd3);
      wait_valid4(lat, saw);
      tests++;
      if (out_valid4 !== 1'b1) begin fails++; $display("[TB] FAIL basic_timeout got out_valid %0b want 1", out_valid4); end
      tests++;
      if (lat != exp_cyc4(5, 3) + 1) begin fails++; $display("[TB] FAIL basic_latency got %0d want %0d", lat, exp_cyc4(5, 3) + 1); end
      tests++;
      if (product4 !== 8'd15) begin fails++; $display("[TB] FAIL basic_product got %0d want 15", product4); end
      tests++;
      if (cycles4 !== 9'(exp_cyc4(5, 3))) begin fails++; $display("[TB] FAIL basic_cycles got %0d want %0d", cycles4, exp_cyc4(5, 3)); end
      tests++;
      if (saw !== 1'b0) begin fails++; $display("[TB] FAIL basic_in_ready_low got %0b want 0", saw); end
      finish4();
      tests++;
      if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
         fails++; $display("[TB] FAIL basic_release got in_ready %0b out_valid %0b want 1 0", in_ready4, out_valid4);
      end
   endtask

   task automatic test_zero_operand;
      int lat;
      bit saw;
      start4(4'd9, 4'd0);
      wait_valid4(lat, saw);
      tests++;
      if (lat != exp_cyc4(9, 0) + 1) begin fails++; $display("[TB] FAIL zero_latency got %0d want %0d", lat, exp_cyc4(9, 0) + 1); end
      tests++;
      if (product4 !== 8'd0) begin fails++; $display("[TB] FAIL zero_product got %0d want 0", product4); end
      tests++;
      if (cycles4 !== 9'(exp_cyc4(9, 0))) begin fails++; $display("[TB] FAIL zero_cycles got %0d want %0d", cycles4, exp_cyc4(9, 0)); end
      finish4();
      start4(4'd15, 4'd15);
      wait_valid4(lat, saw);
      tests++;
      if (product4 !== 8'd225) begin fails++; $display("[TB] FAIL max_product got %0d want 225", product4); end
      tests++;
      if (cycles4 !== 9'(exp_cyc4(15, 15))) begin fails++; $display("[TB] FAIL max_cycles got %0d want %0d", cycles4, exp_cyc4(15, 15)); end
      finish4();
   endtask

   task automatic test_backpressure;
      int lat;
      bit saw;
      start4(4'd3, 4'd2);
      wait_valid4(lat, saw);
      tests++;
      if (product4 !== 8'd6) begin fails++; $display("[TB] FAIL bp_product got %0d want 6", product4); end
      @(negedge clk);
      a4 = 4'd4;
      b4 = 4'd4;
      in_valid4 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         tests++;
         if (out_valid4 !== 1'b1 || product4 !== 8'd6 || cycles4 !== 9'(exp_cyc4(3, 2)) || in_ready4 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_hold cycle %0d got ov %0b p %0d c %0d ir %0b want 1 6 %0d 0",
                     i, out_valid4, product4, cycles4, in_ready4, exp_cyc4(3, 2));
         end
      end
      @(negedge clk);
      out_ready4 = 1'b1;
      @(posedge clk);
      #1;
      out_ready4 = 1'b0;
      tests++;
      if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
         fails++; $display("[TB] FAIL bp_release got ov %0b ir %0b want 0 1", out_valid4, in_ready4);
      end
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      tests++;
      if (busy4 !== 1'b1) begin fails++; $display("[TB] FAIL bp_accept got busy %0b want 1", busy4); end
      wait_valid4(lat, saw);
      tests++;
      if (product4 !== 8'd16) begin fails++; $display("[TB] FAIL bp_next_product got %0d want 16", product4); end
      tests++;
      if (cycles4 !== 9'(exp_cyc4(4, 4))) begin fails++; $display("[TB] FAIL bp_next_cycles got %0d want %0d", cycles4, exp_cyc4(4, 4)); end
      finish4();
   endtask

   task automatic test_reset_mid_run;
      int lat;
      bit saw;
      bit stray;
      start4(4'd7, 4'd7);
      repeat (19) @(posedge clk);
      #1;
      tests++;
      if (busy4 !== 1'b1 || out_valid4 !== 1'b0) begin
         fails++; $display("[TB] FAIL midrun_state got busy %0b ov %0b want 1 0", busy4, out_valid4);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (busy4 !== 1'b0 || out_valid4 !== 1'b0 || product4 !== 8'd0 || cycles4 !== 9'd0) begin
         fails++; $display("[TB] FAIL midrun_reset got busy %0b ov %0b p %0d c %0d want 0 0 0 0",
                           busy4, out_valid4, product4, cycles4);
      end
      @(negedge clk);
      rst = 1'b1;
      stray = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (out_valid4 || busy4) stray = 1'b1;
      end
      tests++;
      if (stray !== 1'b0) begin fails++; $display("[TB] FAIL midrun_no_result got %0b want 0", stray); end
      start4(4'd2, 4'd3);
      wait_valid4(lat, saw);
      tests++;
      if (product4 !== 8'd6) begin fails++; $display("[TB] FAIL midrun_next_product got %0d want 6", product4); end
      finish4();
   endtask

   task automatic test_random_sweep;
      int a;
      int b;
      int lat;
      int stall;
      for (int i = 0; i < 500; i++) begin
         a = $urandom_range(0, 7);
         b = $urandom_range(0, 7);
         @(negedge clk);
         tests++;
         if (in_ready3 !== 1'b1) begin fails++; $display("[TB] FAIL rnd_ready #%0d got %0b want 1", i, in_ready3); end
         a3 = 3'(a);
         b3 = 3'(b);
         in_valid3 = 1'b1;
         @(posedge clk);
         #1;
         in_valid3 = 1'b0;
         tests++;
         if (busy3 !== 1'b1) begin fails++; $display("[TB] FAIL rnd_busy #%0d got %0b want 1", i, busy3); end
         lat = 1;
         while (!out_valid3 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
         end
         stall = $urandom_range(0, 3);
         repeat (stall) @(posedge clk);
         #1;
         tests++;
         if (out_valid3 !== 1'b1 || product3 !== 6'(a * b)) begin
            fails++; $display("[TB] FAIL rnd_product a=%0d b=%0d got ov %0b p %0d want 1 %0d", a, b, out_valid3, product3, a * b);
         end
         tests++;
         if (cycles3 !== 7'(exp_cyc3(a, b))) begin
            fails++; $display("[TB] FAIL rnd_cycles a=%0d b=%0d got %0d want %0d", a, b, cycles3, exp_cyc3(a, b));
         end
         @(negedge clk);
         out_ready3 = 1'b1;
         @(posedge clk);
         #1;
         out_ready3 = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_operand();
      test_backpressure();
      test_reset_mid_run();
      test_random_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
